// File: rtl/spy_probe_pkg.sv
// Shared types and widths for the spy path prober.
package spy_probe_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DELAY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } probeState_t;

  // A requested capture delay of zero still needs one edge between launch and capture.
  function automatic logic [DELAY_W-1:0] effDelay(input logic [DELAY_W-1:0] d);
    return (d == '0) ? DELAY_W'(1) : d;
  endfunction

endpackage

// File: rtl/spy_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module spy_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/spy_path_prober.sv
// Launches alternating edges into an external delay chain and counts captures
// that disagree with the launched polarity after a programmable number of edges.
module spy_path_prober
  import spy_probe_pkg::*;
#(
  parameter bit          CHAIN_INVERTING = 1'b0,
  parameter int unsigned SETTLE_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] trials,
  input  logic [DELAY_W-1:0] captureDelay,
  output logic               pathInput,
  input  logic               pathResult,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] trialCount,
  output logic [COUNT_W-1:0] errorCount
);

  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);

  probeState_t        state;
  logic [COUNT_W-1:0] trialsLat;
  logic [DELAY_W-1:0] delayLat;
  logic [DELAY_W-1:0] delayCnt;
  logic [15:0]        settleCnt;
  logic               captured;

  logic               startAccept;
  logic               expectedBit;
  logic               mismatchInc;
  logic [COUNT_W-1:0] trialNext;

  always_comb begin
    startAccept = 1'b0;
    expectedBit = 1'b0;
    mismatchInc = 1'b0;
    trialNext   = '0;
    startAccept = (state == ST_IDLE) && start;
    expectedBit = pathInput ^ CHAIN_INVERTING;
    mismatchInc = (state == ST_CHECK) && (captured != expectedBit);
    trialNext   = trialCount + COUNT_W'(1);
  end

  spy_sat_counter #(
    .WIDTH(COUNT_W)
  ) errorCounter (
    .clk  (clk),
    .rst  (rst),
    .clr  (startAccept),
    .inc  (mismatchInc),
    .count(errorCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pathInput  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trialCount <= '0;
      trialsLat  <= '0;
      delayLat   <= '0;
      delayCnt   <= '0;
      settleCnt  <= '0;
      captured   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            trialsLat  <= trials;
            delayLat   <= effDelay(captureDelay);
            trialCount <= '0;
            settleCnt  <= '0;
            if (trials == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_SETTLE;
              busy  <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settleCnt == SETTLE_LAST) begin
            // Launch edge; the WAIT count starts at 1 so delay D captures D edges later.
            pathInput <= ~pathInput;
            delayCnt  <= DELAY_W'(1);
            state     <= ST_WAIT;
          end else begin
            settleCnt <= settleCnt + 16'd1;
          end
        end
        ST_WAIT: begin
          if (delayCnt == delayLat) begin
            captured <= pathResult;
            state    <= ST_CHECK;
          end else begin
            delayCnt <= delayCnt + DELAY_W'(1);
          end
        end
        ST_CHECK: begin
          trialCount <= trialNext;
          if (trialNext == trialsLat) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= ST_SETTLE;
            settleCnt <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spy_path_prober.sv
// Directed bench for spy_path_prober using behavioural chain models.
module tb_spy_path_prober;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] trials;
  logic [3:0]  captureDelay;
  logic        startV   [3];
  logic        pathInV  [3];
  logic        pathResV [3];
  logic        busyV    [3];
  logic        doneV    [3];
  logic [15:0] tcV      [3];
  logic [15:0] ecV      [3];

  int nVec = 0;
  int nBad = 0;

  // Chain models: 0 = combinational (1-cycle path), 1 = two flops (3-cycle path), 2 = inverter.
  logic [1:0] modeA;
  logic       dly0, dly1;
  always @(posedge clk) begin
    dly0 <= pathInV[0];
    dly1 <= dly0;
  end
  always_comb begin
    case (modeA)
      2'd0:    pathResV[0] = pathInV[0];
      2'd1:    pathResV[0] = dly1;
      default: pathResV[0] = ~pathInV[0];
    endcase
    pathResV[1] = ~pathInV[1];
    pathResV[2] = 1'b0;
  end

  spy_path_prober #(.CHAIN_INVERTING(1'b0), .SETTLE_CYCLES(8)) dutA (
    .clk(clk), .rst(rst), .start(startV[0]), .trials(trials), .captureDelay(captureDelay),
    .pathInput(pathInV[0]), .pathResult(pathResV[0]), .busy(busyV[0]), .done(doneV[0]),
    .trialCount(tcV[0]), .errorCount(ecV[0]));

  spy_path_prober #(.CHAIN_INVERTING(1'b1), .SETTLE_CYCLES(8)) dutB (
    .clk(clk), .rst(rst), .start(startV[1]), .trials(trials), .captureDelay(captureDelay),
    .pathInput(pathInV[1]), .pathResult(pathResV[1]), .busy(busyV[1]), .done(doneV[1]),
    .trialCount(tcV[1]), .errorCount(ecV[1]));

  spy_path_prober #(.CHAIN_INVERTING(1'b0), .SETTLE_CYCLES(1)) dutC (
    .clk(clk), .rst(rst), .start(startV[2]), .trials(trials), .captureDelay(captureDelay),
    .pathInput(pathInV[2]), .pathResult(pathResV[2]), .busy(busyV[2]), .done(doneV[2]),
    .trialCount(tcV[2]), .errorCount(ecV[2]));

  logic       satClr, satInc;
  logic [2:0] satCount;
  spy_sat_counter #(.WIDTH(3)) satU (
    .clk(clk), .rst(rst), .clr(satClr), .inc(satInc), .count(satCount));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int d, input logic [15:0] tr, input logic [3:0] cd);
    trials       = tr;
    captureDelay = cd;
    startV[d]    = 1'b1;
    tick();
    startV[d]    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int d, input int budget, output int cyc);
    bit busyOk;
    busyOk = 1'b1;
    cyc    = 0;
    while (doneV[d] !== 1'b1 && cyc < budget) begin
      if (busyV[d] !== 1'b1) busyOk = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, "_doneSeen"}, 32'(doneV[d]), 32'd1);
    chk({tag, "_busyRun"}, 32'(busyOk), 32'd1);
    chk({tag, "_busyAtDone"}, 32'(busyV[d]), 32'd0);
    tick();
    chk({tag, "_doneWidth"}, 32'(doneV[d]), 32'd0);
  endtask

  task automatic runAndCheck(input string tag, input int d, input logic [15:0] tr,
                             input logic [3:0] cd, input int budget, input int expCyc,
                             input int expTc, input int expEc, input logic expPin);
    int cyc;
    pulseStart(d, tr, cd);
    waitDone(tag, d, budget, cyc);
    chk({tag, "_cycles"}, 32'(cyc), 32'(expCyc));
    chk({tag, "_trialCount"}, 32'(tcV[d]), 32'(expTc));
    chk({tag, "_errorCount"}, 32'(ecV[d]), 32'(expEc));
    chk({tag, "_pathInput"}, 32'(pathInV[d]), 32'(expPin));
  endtask

  initial begin
    int  cyc;
    bit  sawDone;
    bit  sawBusy;
    rst          = 1'b1;
    trials       = '0;
    captureDelay = '0;
    modeA        = 2'd0;
    satClr       = 1'b0;
    satInc       = 1'b0;
    for (int i = 0; i < 3; i++) startV[i] = 1'b0;
    repeat (3) tick();

    chk("rst_pathInput", 32'(pathInV[0]), 32'd0);
    chk("rst_busy", 32'(busyV[0]), 32'd0);
    chk("rst_done", 32'(doneV[0]), 32'd0);
    chk("rst_trialCount", 32'(tcV[0]), 32'd0);
    chk("rst_errorCount", 32'(ecV[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Saturation on a narrow counter instance
    satInc = 1'b1;
    repeat (6) tick();
    chk("sat_mid", 32'(satCount), 32'd6);
    repeat (4) tick();
    chk("sat_hold", 32'(satCount), 32'd7);
    satInc = 1'b0;
    satClr = 1'b1;
    tick();
    chk("sat_clr", 32'(satCount), 32'd0);
    satClr = 1'b0;

    // Zero-delay chain: 4 trials of 8+1+1 cycles
    modeA = 2'd0;
    runAndCheck("zeroDly", 0, 16'd4, 4'd1, 200, 40, 4, 0, 1'b0);

    // trials=0: straight to DONE, counters cleared, busy never set
    pulseStart(0, 16'd0, 4'd5);
    chk("zeroTr_done", 32'(doneV[0]), 32'd1);
    chk("zeroTr_busy", 32'(busyV[0]), 32'd0);
    chk("zeroTr_trialCount", 32'(tcV[0]), 32'd0);
    chk("zeroTr_errorCount", 32'(ecV[0]), 32'd0);
    tick();
    chk("zeroTr_doneWidth", 32'(doneV[0]), 32'd0);
    chk("zeroTr_busyAfter", 32'(busyV[0]), 32'd0);

    // 3-cycle chain
    modeA = 2'd1;
    repeat (4) tick();
    runAndCheck("dly2", 0, 16'd6, 4'd2, 300, 66, 6, 6, 1'b0);
    runAndCheck("dly3", 0, 16'd6, 4'd3, 300, 72, 6, 0, 1'b0);
    runAndCheck("dly0", 0, 16'd6, 4'd0, 300, 60, 6, 6, 1'b0);

    // Inverting chain, matched and unmatched polarity parameter
    runAndCheck("invMatch", 1, 16'd5, 4'd1, 300, 50, 5, 0, 1'b1);
    modeA = 2'd2;
    runAndCheck("invMismatch", 0, 16'd5, 4'd1, 300, 50, 5, 5, 1'b1);

    // start during a run must be ignored
    modeA = 2'd0;
    pulseStart(0, 16'd4, 4'd1);
    repeat (13) tick();
    trials       = 16'd2;
    captureDelay = 4'd5;
    startV[0]    = 1'b1;
    tick();
    startV[0]    = 1'b0;
    chk("ignore_midCount", 32'(tcV[0]), 32'd1);
    waitDone("ignore", 0, 200, cyc);
    chk("ignore_cycles", 32'(cyc), 32'd26);
    chk("ignore_trialCount", 32'(tcV[0]), 32'd4);
    chk("ignore_errorCount", 32'(ecV[0]), 32'd0);
    chk("ignore_pathInput", 32'(pathInV[0]), 32'd1);

    // Stuck-at-0 chain: every rising launch mismatches
    runAndCheck("stuck0", 2, 16'd9999, 4'd1, 31000, 29997, 9999, 5000, 1'b1);

    // Reset during WAIT of trial 3 (launch at edge 32, WAIT edges 33..35)
    pulseStart(0, 16'd6, 4'd3);
    repeat (33) tick();
    chk("abort_preCount", 32'(tcV[0]), 32'd2);
    rst = 1'b1;
    tick();
    chk("abort_pathInput", 32'(pathInV[0]), 32'd0);
    chk("abort_busy", 32'(busyV[0]), 32'd0);
    chk("abort_trialCount", 32'(tcV[0]), 32'd0);
    chk("abort_errorCount", 32'(ecV[0]), 32'd0);
    chk("abort_done", 32'(doneV[0]), 32'd0);
    rst     = 1'b0;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    repeat (30) begin
      tick();
      if (doneV[0] !== 1'b0) sawDone = 1'b1;
      if (busyV[0] !== 1'b0) sawBusy = 1'b1;
    end
    chk("abort_noDone", 32'(sawDone), 32'd0);
    chk("abort_stayIdle", 32'(sawBusy), 32'd0);
    runAndCheck("postRst", 0, 16'd2, 4'd1, 200, 20, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
